icache_sa: RTL and testbench

//  Parametrised set-associative instruction cache between insqueue fetch and memory controller.

---
 rtl/icache_sa.sv | 188 ++++++++++++++++++
 tb/tb_icache_sa.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/icache_sa.sv
// icache_sa: set-associative instruction cache (1 or 2 ways, LRU) that sits
// between the fetch stage and the memory controller. Lookups are combinational.
// A miss refills the whole line, one 32-bit word per accepted beat.
// Optional feature macro: ICACHE_PERF_EN adds the hit_cnt/miss_cnt counters.
module icache_sa #(
   parameter int INDEX_BITS      = 6,
   parameter int WAYS            = 2,
   parameter int LINE_WORDS_LOG2 = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        clear_flag,
   input  logic        fetch_valid,
   input  logic [31:0] fetch_addr,
   output logic        fetch_hit,
   output logic [31:0] fetch_inst,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_data,
   output logic        busy
`ifdef ICACHE_PERF_EN
   ,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
`endif
);

   localparam int SETS    = 2 ** INDEX_BITS;
   localparam int LW      = 2 ** LINE_WORDS_LOG2;
   localparam int IDX_LSB = LINE_WORDS_LOG2 + 2;
   localparam int TAG_LSB = IDX_LSB + INDEX_BITS;
   localparam int TAG_W   = 32 - TAG_LSB;
   localparam int LINE_W  = 32 - IDX_LSB;

   typedef enum logic {IDLE, REFILL} state_t;

   state_t state_q, state_d;

   // Storage is sized for two ways; with WAYS=1 way 1 is never allocated.
   logic [31:0]            data_q  [2][SETS][LW];
   logic [TAG_W-1:0]       tag_q   [2][SETS];
   logic [1:0][SETS-1:0]   valid_q;
   logic [SETS-1:0]        lru_q;

   logic [LINE_W-1:0]          line_q;   // {tag,idx} of the line being refilled
   logic                       victim_q;
   logic [LINE_WORDS_LOG2-1:0] beat_q;

   logic [INDEX_BITS-1:0]      f_idx;
   logic [TAG_W-1:0]           f_tag;
   logic [LINE_WORDS_LOG2-1:0] f_off;
   logic [INDEX_BITS-1:0]      r_idx;
   logic [TAG_W-1:0]           r_tag;

   logic        hit_any, hit_way, victim_sel;
   logic [31:0] hit_word;
   logic        lookup_ok, miss_start, ack_fire, last_beat;
   logic [LINE_WORDS_LOG2:0] beat_inc;
   logic [31:0] addr_next;

   assign f_off = fetch_addr[IDX_LSB-1:2];
   assign f_idx = fetch_addr[TAG_LSB-1:IDX_LSB];
   assign f_tag = fetch_addr[31:TAG_LSB];
   assign r_idx = line_q[INDEX_BITS-1:0];
   assign r_tag = line_q[LINE_W-1:INDEX_BITS];

   // Tag compare across the configured ways; at most one way can match.
   always_comb begin
      hit_any  = 1'b0;
      hit_way  = 1'b0;
      hit_word = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[w][f_idx] && tag_q[w][f_idx] == f_tag) begin
            hit_any  = 1'b1;
            hit_way  = w[0];
            hit_word = data_q[w[0]][f_idx][f_off];
         end
      end
   end

   // Victim: first invalid way, otherwise the LRU way of the set.
   always_comb begin
      if (!valid_q[0][f_idx])
         victim_sel = 1'b0;
      else if (WAYS == 2 && !valid_q[1][f_idx])
         victim_sel = 1'b1;
      else
         victim_sel = lru_q[f_idx];
   end

   // No lookups while refilling or flushing; reset also masks the stale arrays.
   assign lookup_ok  = fetch_valid && state_q == IDLE && !clear_flag && !rst;
   assign fetch_hit  = lookup_ok && hit_any;
   assign fetch_inst = fetch_hit ? hit_word : 32'h0;
   assign miss_start = lookup_ok && !hit_any && rdy;
   assign ack_fire   = state_q == REFILL && mem_req && mem_ack && rdy && !clear_flag;
   assign last_beat  = beat_q == LINE_WORDS_LOG2'(LW - 1);
   assign busy       = state_q == REFILL;

   assign beat_inc  = {1'b0, beat_q} + 1'b1;
   assign addr_next = {line_q, {IDX_LSB{1'b0}}} + (32'(beat_inc) << 2);

   // Next-state logic: stall on ~rdy, flush wins over refill progress.
   always_comb begin
      state_d = state_q;
      if (!rdy)
         state_d = state_q;
      else if (clear_flag)
         state_d = IDLE;
      else begin
         case (state_q)
            IDLE:    if (miss_start) state_d = REFILL;
            REFILL:  if (ack_fire && last_beat) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Control state: valid/LRU bits, refill bookkeeping and memory request.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= '0;
         lru_q    <= '0;
         beat_q   <= '0;
         mem_req  <= 1'b0;
         mem_addr <= '0;
         line_q   <= '0;
         victim_q <= 1'b0;
      end else if (rdy) begin
         if (clear_flag) begin
            valid_q <= '0;
            lru_q   <= '0;
            beat_q  <= '0;
            mem_req <= 1'b0;
         end else if (state_q == IDLE) begin
            if (fetch_hit)
               lru_q[f_idx] <= (WAYS == 2) ? ~hit_way : 1'b0;
            else if (miss_start) begin
               line_q                  <= fetch_addr[31:IDX_LSB];
               victim_q                <= victim_sel;
               valid_q[victim_sel][f_idx] <= 1'b0;
               beat_q                  <= '0;
               mem_req                 <= 1'b1;
               mem_addr                <= {fetch_addr[31:IDX_LSB], {IDX_LSB{1'b0}}};
            end
         end else if (ack_fire) begin
            beat_q   <= beat_inc[LINE_WORDS_LOG2-1:0];
            mem_addr <= addr_next;
            if (last_beat) begin
               valid_q[victim_q][r_idx] <= 1'b1;
               lru_q[r_idx]             <= (WAYS == 2) ? ~victim_q : 1'b0;
               mem_req                  <= 1'b0;
            end
         end
      end
   end

   // Data and tag arrays: written only by accepted refill beats.
   always_ff @(posedge clk) begin
      if (!rst && ack_fire) begin
         data_q[victim_q][r_idx][beat_q] <= mem_data;
         if (last_beat)
            tag_q[victim_q][r_idx] <= r_tag;
      end
   end

`ifdef ICACHE_PERF_EN
   // Event counters survive flushes; only reset clears them.
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (rdy && !clear_flag) begin
         if (fetch_hit)  hit_cnt  <= hit_cnt + 32'd1;
         if (miss_start) miss_cnt <= miss_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_icache_sa.sv
// Directed bench for icache_sa (default parameters: 64 sets, 2 ways, 4-word lines).
module tb_icache_sa;

   logic        clk = 1'b0;
   logic        rst, rdy, clear_flag, fetch_valid, mem_ack;
   logic [31:0] fetch_addr, mem_data, mem_addr, fetch_inst;
   logic        fetch_hit, mem_req, busy;
`ifdef ICACHE_PERF_EN
   logic [31:0] hit_cnt, miss_cnt;
`endif

   int n_vec = 0;
   int n_bad = 0;

   icache_sa dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clear_flag(clear_flag),
      .fetch_valid(fetch_valid), .fetch_addr(fetch_addr),
      .fetch_hit(fetch_hit), .fetch_inst(fetch_inst),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_data(mem_data), .busy(busy)
`ifdef ICACHE_PERF_EN
      , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        exp_hit;
      logic [31:0] exp_inst;
   } probe_vec_t;

   probe_vec_t tbl [10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Combinational lookup without letting it reach a clock edge.
   task automatic probe(input string name, input logic [31:0] addr,
                        input logic exp_hit, input logic [31:0] exp_inst);
      fetch_valid = 1'b1;
      fetch_addr  = addr;
      #1;
      chk({name, " hit"}, 32'(fetch_hit), 32'(exp_hit));
      chk({name, " inst"}, fetch_inst, exp_inst);
      fetch_valid = 1'b0;
   endtask

   // Lookup that is presented at an edge (commits LRU / counters).
   task automatic fetch_edge(input logic [31:0] addr);
      fetch_valid = 1'b1;
      fetch_addr  = addr;
      tick();
      fetch_valid = 1'b0;
   endtask

   task automatic start_miss(input string name, input logic [31:0] addr);
      fetch_edge(addr);
      chk({name, " busy"}, 32'(busy), 32'd1);
      chk({name, " req"}, 32'(mem_req), 32'd1);
      chk({name, " addr0"}, mem_addr, addr & 32'hFFFF_FFF0);
   endtask

   task automatic beat(input string name, input logic [31:0] exp_addr, input logic [31:0] d);
      chk({name, " beat req"}, 32'(mem_req), 32'd1);
      chk({name, " beat addr"}, mem_addr, exp_addr);
      mem_ack  = 1'b1;
      mem_data = d;
      tick();
      mem_ack  = 1'b0;
   endtask

   task automatic fill(input string name, input logic [31:0] base, input logic [31:0] d0);
      start_miss(name, base);
      for (int i = 0; i < 4; i++) beat(name, base + 32'(4 * i), d0 + 32'(i));
      chk({name, " done busy"}, 32'(busy), 32'd0);
      chk({name, " done req"}, 32'(mem_req), 32'd0);
   endtask

   initial begin
      tbl[0] = '{32'h200, 1'b1, 32'hE0};
      tbl[1] = '{32'h20C, 1'b1, 32'hE3};
      tbl[2] = '{32'h20A, 1'b1, 32'hE2};   // low address bits ignored
      tbl[3] = '{32'h608, 1'b1, 32'hF2};
      tbl[4] = '{32'h000, 1'b1, 32'hB0};
      tbl[5] = '{32'h004, 1'b1, 32'hB1};
      tbl[6] = '{32'h30C, 1'b1, 32'h33};
      tbl[7] = '{32'h100, 1'b0, 32'h0};    // wiped by the flush
      tbl[8] = '{32'hA00, 1'b0, 32'h0};    // same set as 0x200/0x600, other tag
      tbl[9] = '{32'h400, 1'b0, 32'h0};

      rst = 1'b1; rdy = 1'b1; clear_flag = 1'b0; fetch_valid = 1'b0;
      fetch_addr = '0; mem_ack = 1'b0; mem_data = '0;
      tick(); tick();
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst req", 32'(mem_req), 32'd0);
      chk("rst addr", mem_addr, 32'h0);
      rst = 1'b0;
      probe("cold", 32'h100, 1'b0, 32'h0);

      // 1: cold miss and refill
      fill("cold", 32'h100, 32'hA0);
      probe("cold 108", 32'h108, 1'b1, 32'hA2);

      // 2: LRU eviction in set 0
      fill("lru a", 32'h000, 32'hB0);
      fill("lru b", 32'h400, 32'hC0);
      fetch_edge(32'h000);
      fill("lru c", 32'h800, 32'hD0);
      probe("lru 000", 32'h000, 1'b1, 32'hB0);
      probe("lru 404", 32'h404, 1'b0, 32'h0);
      probe("lru 80C", 32'h80C, 1'b1, 32'hD3);

      // 3: flush mid-refill; the concurrent ack must be dropped
      start_miss("fl", 32'h200);
      beat("fl", 32'h200, 32'h11);
      beat("fl", 32'h204, 32'h12);
      clear_flag = 1'b1; mem_ack = 1'b1; mem_data = 32'h13;
      tick();
      clear_flag = 1'b0; mem_ack = 1'b0;
      chk("fl req", 32'(mem_req), 32'd0);
      chk("fl busy", 32'(busy), 32'd0);
      probe("fl 000", 32'h000, 1'b0, 32'h0);
      fill("fl re", 32'h200, 32'hE0);
      probe("fl 204", 32'h204, 1'b1, 32'hE1);

      // 4: rdy stall with mem_ack held high
      start_miss("st", 32'h600);
      beat("st", 32'h600, 32'hF0);
      rdy = 1'b0; mem_ack = 1'b1; mem_data = 32'hF1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("st addr", mem_addr, 32'h604);
         chk("st busy", 32'(busy), 32'd1);
      end
      rdy = 1'b1; mem_ack = 1'b0;
      for (int i = 1; i < 4; i++) beat("st", 32'h600 + 32'(4 * i), 32'hF0 + 32'(i));
      chk("st done", 32'(busy), 32'd0);
      probe("st 604", 32'h604, 1'b1, 32'hF1);

      // 5: no hit-under-miss
      fill("hum a", 32'h000, 32'hB0);
      start_miss("hum", 32'h300);
      probe("hum 000", 32'h000, 1'b0, 32'h0);
      beat("hum", 32'h300, 32'h30);
      probe("hum 000b", 32'h000, 1'b0, 32'h0);
      for (int i = 1; i < 4; i++) beat("hum", 32'h300 + 32'(4 * i), 32'h30 + 32'(i));

      foreach (tbl[i]) probe($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].exp_hit, tbl[i].exp_inst);

`ifdef ICACHE_PERF_EN
      // 6: performance counters
      rst = 1'b1; tick(); rst = 1'b0;
      chk("perf rst hit", hit_cnt, 32'd0);
      chk("perf rst miss", miss_cnt, 32'd0);
      fill("perf", 32'h100, 32'hA0);
      for (int i = 0; i < 3; i++) fetch_edge(32'h104);
      chk("perf hit", hit_cnt, 32'd3);
      chk("perf miss", miss_cnt, 32'd1);
      clear_flag = 1'b1; tick(); clear_flag = 1'b0;
      chk("perf clr hit", hit_cnt, 32'd3);
      chk("perf clr miss", miss_cnt, 32'd1);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("perf rst2 hit", hit_cnt, 32'd0);
      chk("perf rst2 miss", miss_cnt, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
